// File: rtl/usb_speed_autodetect_pkg.sv
// Shared USB speed / linestate codes and the PHY select mapping for a detected speed.
package usb_speed_autodetect_pkg;

  typedef enum logic [1:0] {
    USB_SPEED_AUTO = 2'b00,
    USB_SPEED_LS   = 2'b01,
    USB_SPEED_FS   = 2'b10,
    USB_SPEED_HS   = 2'b11
  } usb_speed_e;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_J   = 2'b01,
    LINE_K   = 2'b10,
    LINE_SE1 = 2'b11
  } linestate_e;

  // {xcvrsel, termsel} the PHY should use once the link speed is known
  function automatic logic [2:0] phy_sel(input usb_speed_e speed);
    case (speed)
      USB_SPEED_HS: return 3'b000;
      USB_SPEED_LS: return 3'b101;
      default:      return 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/usb_speed_autodetect_if.sv
// Register-block / PHY side signals of the speed autodetector.
interface usb_speed_autodetect_if #(
  parameter int unsigned pUSB_AUTO_COUNTER_WIDTH = 24
);
  logic                               I_restart;
  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait1;
  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait2;
  logic [1:0]                         I_xcvrsel_default;
  logic                               I_termsel_default;
  logic [1:0]                         I_linestate;
  logic [1:0]                         O_speed;
  logic                               O_done;
  logic                               O_busy;
  logic [1:0]                         O_xcvrsel;
  logic                               O_termsel;

  modport master (
    output I_restart, I_wait1, I_wait2, I_xcvrsel_default, I_termsel_default, I_linestate,
    input  O_speed, O_done, O_busy, O_xcvrsel, O_termsel
  );

  modport slave (
    input  I_restart, I_wait1, I_wait2, I_xcvrsel_default, I_termsel_default, I_linestate,
    output O_speed, O_done, O_busy, O_xcvrsel, O_termsel
  );
endinterface

// File: rtl/usb_run_counter.sv
// Saturating counter of consecutive matching cycles; o_hit flags the cycle the run reaches pTHRESHOLD.
module usb_run_counter #(
  parameter int unsigned pWIDTH     = 9,
  parameter int unsigned pTHRESHOLD = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_match,
  output logic o_hit
);

  localparam logic [pWIDTH-1:0] cHIT_AT = pWIDTH'((pTHRESHOLD > 1) ? pTHRESHOLD - 1 : 0);
  localparam logic [pWIDTH-1:0] cONE    = pWIDTH'(1);

  logic [pWIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clear || !i_match)
      r_count <= '0;
    else if (r_count != '1)
      r_count <= r_count + cONE;
  end

  // Hit is combinational so the owner can change state on the Nth matching cycle itself
  assign o_hit = i_match && !i_clear && (r_count >= cHIT_AT);

endmodule

// File: rtl/usb_speed_autodetect.sv
// Detects LS/FS/HS after a restart by watching PHY linestate for settle, bus reset and chirp K.
module usb_speed_autodetect
  import usb_speed_autodetect_pkg::*;
#(
  parameter int unsigned pUSB_AUTO_COUNTER_WIDTH = 24,
  parameter int unsigned pSE0_MIN_CYCLES         = 150,
  parameter int unsigned pCHIRP_MIN_CYCLES       = 150
) (
  input logic                    fe_clk,
  input logic                    reset_i,
  usb_speed_autodetect_if.slave  bus
);

  localparam int unsigned W = pUSB_AUTO_COUNTER_WIDTH;
  localparam logic [W-1:0] cONE = W'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_WAIT_RESET, ST_CHIRP, ST_DONE
  } state_e;

  state_e     r_state;
  logic [W-1:0] r_cnt, r_wait1, r_wait2;
  usb_speed_e r_speed;
  logic       r_done, r_busy, r_termsel;
  logic [1:0] r_xcvrsel;

  logic [W-1:0] w_lim1, w_lim2, w_cnt_inc;
  logic         w_term1, w_term2, w_is_se0, w_is_k, w_se0_hit, w_k_hit;
  logic         w_se0_clear, w_k_clear, w_fin;
  usb_speed_e   w_fin_speed;

  assign w_lim1    = (r_wait1 == '0) ? '0 : r_wait1 - cONE;
  assign w_lim2    = (r_wait2 == '0) ? '0 : r_wait2 - cONE;
  assign w_term1   = (r_cnt >= w_lim1);
  assign w_term2   = (r_cnt >= w_lim2);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + cONE;

  assign w_is_se0    = (bus.I_linestate == LINE_SE0);
  assign w_is_k      = (bus.I_linestate == LINE_K);
  assign w_se0_clear = bus.I_restart || (r_state != ST_WAIT_RESET);
  assign w_k_clear   = bus.I_restart || (r_state != ST_CHIRP);

  usb_run_counter #(
    .pWIDTH($clog2(pSE0_MIN_CYCLES + 1) + 1),
    .pTHRESHOLD(pSE0_MIN_CYCLES)
  ) u_se0_run (
    .clk(fe_clk), .rst(reset_i), .i_clear(w_se0_clear), .i_match(w_is_se0), .o_hit(w_se0_hit)
  );

  usb_run_counter #(
    .pWIDTH($clog2(pCHIRP_MIN_CYCLES + 1) + 1),
    .pTHRESHOLD(pCHIRP_MIN_CYCLES)
  ) u_k_run (
    .clk(fe_clk), .rst(reset_i), .i_clear(w_k_clear), .i_match(w_is_k), .o_hit(w_k_hit)
  );

  // Final decisions; timeout outranks the SE0 run in WAIT_RESET, chirp outranks timeout in CHIRP
  always_comb begin
    w_fin       = 1'b0;
    w_fin_speed = USB_SPEED_FS;
    case (r_state)
      ST_SETTLE:
        if (w_term1 && bus.I_linestate == LINE_K) begin
          w_fin       = 1'b1;
          w_fin_speed = USB_SPEED_LS;
        end
      ST_WAIT_RESET:
        w_fin = w_term2;
      ST_CHIRP:
        if (w_k_hit) begin
          w_fin       = 1'b1;
          w_fin_speed = USB_SPEED_HS;
        end else if (w_term2 || bus.I_linestate == LINE_J) begin
          w_fin = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wait1   <= '0;
      r_wait2   <= '0;
      r_speed   <= USB_SPEED_FS;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_xcvrsel <= 2'b01;
      r_termsel <= 1'b1;
    end else if (bus.I_restart) begin
      r_state   <= ST_SETTLE;
      r_cnt     <= '0;
      r_wait1   <= bus.I_wait1;
      r_wait2   <= bus.I_wait2;
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
      r_xcvrsel <= bus.I_xcvrsel_default;
      r_termsel <= bus.I_termsel_default;
    end else if (w_fin) begin
      r_state                <= ST_DONE;
      r_speed                <= w_fin_speed;
      r_done                 <= 1'b1;
      r_busy                 <= 1'b0;
      {r_xcvrsel, r_termsel} <= phy_sel(w_fin_speed);
    end else begin
      if (r_busy) begin
        r_xcvrsel <= bus.I_xcvrsel_default;
        r_termsel <= bus.I_termsel_default;
      end
      case (r_state)
        ST_SETTLE:
          if (w_term1) begin
            r_cnt <= '0;
            if (bus.I_linestate == LINE_J) r_state <= ST_WAIT_RESET;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        ST_WAIT_RESET: begin
          r_cnt <= w_cnt_inc;
          if (w_se0_hit) r_state <= ST_CHIRP;
        end
        ST_CHIRP: r_cnt <= w_cnt_inc;
        default: ;
      endcase
    end
  end

  assign bus.O_speed   = r_speed;
  assign bus.O_done    = r_done;
  assign bus.O_busy    = r_busy;
  assign bus.O_xcvrsel = r_xcvrsel;
  assign bus.O_termsel = r_termsel;

endmodule

// File: tb/tb_usb_speed_autodetect.sv
// Scoreboard bench: per-restart linestate scripts, outcome predicted from the detection rules.
module tb_usb_speed_autodetect;
  import usb_speed_autodetect_pkg::*;

  localparam int unsigned W     = 24;
  localparam int          N_SE0 = 4;
  localparam int          N_K   = 4;

  typedef struct {
    logic [1:0] speed;
    logic [1:0] xcvr;
    logic       term;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [1:0] ls_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_speed_autodetect_if #(.pUSB_AUTO_COUNTER_WIDTH(W)) bus ();

  usb_speed_autodetect #(
    .pUSB_AUTO_COUNTER_WIDTH(W),
    .pSE0_MIN_CYCLES(N_SE0),
    .pCHIRP_MIN_CYCLES(N_K)
  ) dut (
    .fe_clk(clk),
    .reset_i(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [1:0] get_ls(input int k);
    if (k < 0 || ls_q.size() == 0) return LINE_J;
    if (k >= ls_q.size()) return ls_q[ls_q.size()-1];
    return ls_q[k];
  endfunction

  function automatic bit all_eq(input int a, input int b, input logic [1:0] v);
    for (int i = a; i <= b; i++)
      if (get_ls(i) != v) return 1'b0;
    return 1'b1;
  endfunction

  // Outcome from the rules: relative decision cycle dc (restart is cycle 0), done visible at dc+1
  function automatic void model(input int w1, input int w2, output logic [1:0] spd, output int dc);
    int w1e, w2e, t, s, tmo, c;
    w1e = (w1 == 0) ? 1 : w1;
    w2e = (w2 == 0) ? 1 : w2;
    t = w1e;
    while (get_ls(t) != LINE_J) begin
      if (get_ls(t) == LINE_K) begin
        spd = USB_SPEED_LS;
        dc  = t;
        return;
      end
      t += w1e;
    end
    s   = t;
    tmo = s + w2e;
    spd = USB_SPEED_FS;
    dc  = tmo;
    c   = -1;
    for (int x = s + 1; x <= tmo; x++) begin
      if (x == tmo) return;
      if ((x - N_SE0 + 1 > s) && all_eq(x - N_SE0 + 1, x, LINE_SE0)) begin
        c = x;
        break;
      end
    end
    for (int d = c + 1; d <= tmo; d++) begin
      if ((d - N_K + 1 > c) && all_eq(d - N_K + 1, d, LINE_K)) begin
        spd = USB_SPEED_HS;
        dc  = d;
        return;
      end
      if (get_ls(d) == LINE_J || d == tmo) begin
        dc = d;
        return;
      end
    end
  endfunction

  function automatic logic [2:0] exp_phy(input logic [1:0] spd);
    if (spd == USB_SPEED_HS) return 3'b000;
    if (spd == USB_SPEED_LS) return 3'b101;
    return 3'b011;
  endfunction

  task automatic seg(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) ls_q.push_back(v);
  endtask

  task automatic run(input int w1, input int w2, input logic [1:0] xd, input logic td,
                     input int abort_at, input bit expect_it);
    logic [1:0] spd;
    logic [2:0] phy;
    int dc, lim;
    exp_t e;
    @(posedge clk) #1;
    if (sb.size() != 0) begin
      check("missing_done", sb.size(), 0);
      sb.delete();
    end
    model(w1, w2, spd, dc);
    phy = exp_phy(spd);
    if (expect_it) begin
      e.speed = spd;
      e.xcvr  = phy[2:1];
      e.term  = phy[0];
      e.at    = cyc + dc + 1;
      sb.push_back(e);
    end
    bus.I_restart         = 1'b1;
    bus.I_wait1           = W'(w1);
    bus.I_wait2           = W'(w2);
    bus.I_xcvrsel_default = xd;
    bus.I_termsel_default = td;
    bus.I_linestate       = get_ls(0);
    lim = (abort_at > 0) ? abort_at : dc + 3;
    for (int k = 1; k < lim; k++) begin
      @(posedge clk) #1;
      if (k == 1) begin
        check("busy_after_restart", bus.O_busy, 1);
        check("done_after_restart", bus.O_done, 0);
        check("xcvr_while_busy", {bus.O_xcvrsel, bus.O_termsel}, {xd, td});
      end
      bus.I_restart   = 1'b0;
      bus.I_wait1     = W'($urandom);
      bus.I_wait2     = W'($urandom);
      bus.I_linestate = get_ls(k);
    end
  endtask

  // Monitor: pops one expectation per rising O_done
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.O_done && !prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("speed", bus.O_speed, e.speed);
            check("xcvrsel", bus.O_xcvrsel, e.xcvr);
            check("termsel", bus.O_termsel, e.term);
            check("done_cycle", cyc, e.at);
            check("busy_at_done", bus.O_busy, 0);
          end
        end
        prev = bus.O_done;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.I_restart = 1'b0;
    bus.I_wait1 = '0;
    bus.I_wait2 = '0;
    bus.I_xcvrsel_default = 2'b11;
    bus.I_termsel_default = 1'b0;
    bus.I_linestate = LINE_J;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {bus.O_speed, bus.O_done, bus.O_busy, bus.O_xcvrsel, bus.O_termsel},
          {USB_SPEED_FS, 1'b0, 1'b0, 2'b01, 1'b1});
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_start", {bus.O_done, bus.O_busy}, 2'b00);

    // FS by timeout with J throughout
    ls_q.delete(); seg(LINE_J, 1);
    run(10, 1000, 2'b00, 1'b0, 0, 1);
    // LS: K at the settle sample
    ls_q.delete(); seg(LINE_K, 1);
    run(10, 1000, 2'b11, 1'b0, 0, 1);
    // HS: reset then full chirp K
    ls_q.delete(); seg(LINE_J, 11); seg(LINE_SE0, 6); seg(LINE_K, 5); seg(LINE_J, 1);
    run(10, 1000, 2'b01, 1'b1, 0, 1);
    // Chirp too short, J ends it
    ls_q.delete(); seg(LINE_J, 11); seg(LINE_SE0, 6); seg(LINE_K, 3); seg(LINE_J, 1);
    run(10, 1000, 2'b00, 1'b1, 0, 1);
    // SE0 run too short, FS on timeout
    ls_q.delete(); seg(LINE_J, 11); seg(LINE_SE0, 3); seg(LINE_J, 1);
    run(10, 1000, 2'b10, 1'b0, 0, 1);
    // No device for 50 cycles, settle repeats
    ls_q.delete(); seg(LINE_SE0, 51); seg(LINE_J, 1);
    run(10, 1000, 2'b00, 1'b0, 0, 1);
    // Restart mid-CHIRP, then a full rerun to HS
    ls_q.delete(); seg(LINE_J, 11); seg(LINE_SE0, 6); seg(LINE_K, 5); seg(LINE_J, 1);
    run(10, 1000, 2'b01, 1'b0, 18, 0);
    run(10, 1000, 2'b01, 1'b0, 0, 1);
    // Zero wait values behave as 1
    ls_q.delete(); seg(LINE_J, 1);
    run(0, 0, 2'b10, 1'b1, 0, 1);

    // Async reset mid-WAIT_RESET
    ls_q.delete(); seg(LINE_J, 11); seg(LINE_SE0, 2); seg(LINE_J, 1);
    run(10, 1000, 2'b11, 1'b0, 30, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {bus.O_speed, bus.O_done, bus.O_busy, bus.O_xcvrsel, bus.O_termsel},
          {USB_SPEED_FS, 1'b0, 1'b0, 2'b01, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.I_linestate = LINE_K;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_rst", {bus.O_done, bus.O_busy}, 2'b00);

    // Randomized scripts with short waits
    for (int r = 0; r < 24; r++) begin
      int w1, w2, n;
      ls_q.delete();
      w1 = $urandom_range(0, 12);
      w2 = $urandom_range(0, 80);
      while (ls_q.size() < 200) begin
        n = $urandom_range(1, 8);
        case ($urandom_range(0, 5))
          0, 1: seg(LINE_SE0, n);
          2, 3: seg(LINE_K, n);
          4:    seg(LINE_J, n);
          default: seg(LINE_SE1, n);
        endcase
      end
      seg(LINE_J, 1);
      run(w1, w2, 2'($urandom), 1'($urandom), 0, 1);
    end

    repeat (5) @(posedge clk);
    #1;
    if (sb.size() != 0) check("missing_done", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_speed_autodetect.md
Name: usb_speed_autodetect

Overview:
Determines the speed (LS/FS/HS) of the USB link under capture by observing PHY linestate after an autodetect restart. Sits directly downstream of the USB register block: consumes its restart pulse, wait1/wait2 timeouts and xcvrsel/termsel defaults. Feeds back the detected speed, which the register block returns when USB_SPEED_AUTO is selected. Drives PHY xcvrsel/termsel during and after detection.

Parameters:
pUSB_AUTO_COUNTER_WIDTH, 24, width of wait1/wait2 timeout counters
pSE0_MIN_CYCLES, 150, consecutive SE0 cycles recognised as host bus reset (2.5 us at 60 MHz)
pCHIRP_MIN_CYCLES, 150, consecutive K cycles during reset recognised as device chirp K

Ports:
fe_clk  in  1  front-end (PHY) clock; the only clock
reset_i  in  1  reset, asynchronous, active-high
I_restart  in  1  single-cycle restart pulse, already in fe_clk domain (CDC upstream)
I_wait1  in  pUSB_AUTO_COUNTER_WIDTH  settle time, cycles, quasi-static
I_wait2  in  pUSB_AUTO_COUNTER_WIDTH  reset/chirp watch timeout, cycles, quasi-static
I_xcvrsel_default  in  2  PHY xcvrsel used while detecting
I_termsel_default  in  1  PHY termsel used while detecting
I_linestate  in  2  PHY linestate (00 SE0, 01 J, 10 K, 11 SE1)
O_speed  out  2  detected speed, USB_SPEED_HS/FS/LS codes from defines_usb.v
O_done  out  1  level: detection complete, O_speed valid
O_busy  out  1  level: detection in progress
O_xcvrsel  out  2  PHY xcvrsel
O_termsel  out  1  PHY termsel

Behaviour:
- Reset values: O_speed=USB_SPEED_FS, O_done=0, O_busy=0, O_xcvrsel=2'b01, O_termsel=1, state IDLE, counters 0.
- States: IDLE, SETTLE, WAIT_RESET, CHIRP, DONE.
- I_restart in any state (incl. busy): next cycle state=SETTLE, counters cleared, wait1/wait2 latched, O_done=0, O_busy=1. Restart has priority over every other transition in the same cycle.
- While O_busy: O_xcvrsel=I_xcvrsel_default, O_termsel=I_termsel_default (registered, 1-cycle latency).
- SETTLE: count up; terminal when count==max(wait1,1)-1. At terminal, sample linestate: 01 -> WAIT_RESET (candidate FS); 10 -> DONE with LS; 00/11 -> counter reloads to 0, stay SETTLE (no device / invalid).
- WAIT_RESET: timeout counter runs from entry (terminal at max(wait2,1)-1); SE0 run counter counts consecutive 00 and clears on any other value. SE0 run reaching pSE0_MIN_CYCLES -> CHIRP (timeout counter keeps running). Timeout -> DONE with FS.
- CHIRP: K run counter counts consecutive 10. Reaching pCHIRP_MIN_CYCLES -> DONE with HS. Linestate 01 (reset ended, no chirp) -> DONE with FS. Timeout -> DONE with FS. Simultaneous chirp-min and timeout: HS wins.
- DONE (entered one cycle after decision): O_speed updated, O_done=1, O_busy=0; O_xcvrsel/O_termsel: HS -> 00/0, FS -> 01/1, LS -> 10/1. Stays until next restart. IDLE only exits via restart.
- Counters saturate; no wrap. Changing I_wait1/I_wait2 mid-detection has no effect until next restart.
- Reset mid-detection: immediate return to reset values.

Decomposition:
- Speed codes (USB_SPEED_HS/FS/LS/AUTO) and linestate codes (SE0/J/K/SE1) in defines_usb.v; state encodings local.
- One sub-module natural: usb_run_counter (saturating consecutive-match counter with clear, compare to threshold), instantiated for SE0 run and K run.

Test Plan:
- Bench params pSE0_MIN=4, pCHIRP_MIN=4; wait1=10, wait2=1000.
- Restart, linestate=01 throughout -> after 10 settle + 1000 timeout (+1) cycles O_done=1, O_speed=FS, xcvrsel=01, termsel=1.
- Restart, linestate=10 -> O_done=1 at cycle 11, O_speed=LS, xcvrsel=10.
- Restart, J, then SE0 x6, then K x5 -> O_speed=HS, xcvrsel=00, termsel=0, well before timeout.
- J, SE0 x6, K x3, J -> O_speed=FS (chirp too short); SE0 x3 then J -> no CHIRP entry, FS on timeout.
- Restart with linestate=00 for 50 cycles then 01 -> SETTLE repeats until J sampled; restart pulse mid-CHIRP -> O_done drops next cycle, full detection reruns.
- Assert reset_i asynchronously mid-WAIT_RESET -> outputs at reset values within the same cycle, no O_done until next restart.
